// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side packet deframer.
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHK     = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         MAX_LEN_DEFAULT   = 16;

endpackage

// File: rtl/uart_payload_buf.sv
// Payload store: DEPTH x 8 register file, synchronous write, registered read.
module uart_payload_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// Assembles SYNC/LEN/payload/CHK frames from UART receiver bytes, checks them
// and streams good payloads out over valid/ready with a last flag.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int         SYS_CLOCK      = 50000000,
  parameter int         TIMEOUT_CYCLES = SYS_CLOCK / 1000,
  parameter int         MAX_LEN        = MAX_LEN_DEFAULT,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic       i_SysClock,
  input  logic       i_Reset,
  input  logic [7:0] i_RxByte,
  input  logic       i_RxDone,
  output logic [7:0] o_Data,
  output logic       o_Valid,
  output logic       o_Last,
  input  logic       i_Ready,
  output logic       o_FrameOk,
  output logic       o_FrameErr,
  output logic       o_Overrun
);

  localparam int CW  = $clog2(MAX_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BAW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t          state, state_d;
  logic            done_q;
  logic            strobe;
  logic [CW-1:0]   len, len_d, idx, idx_d, rd, rd_d;
  logic [7:0]      sum, sum_d;
  logic [TW-1:0]   timer, timer_d;
  logic            timer_run, timeout;
  logic            ok_d, err_d, ovr_d, last_d, we;
  logic            len_bad;

  assign strobe  = i_RxDone & ~done_q;
  assign len_bad = (i_RxByte == 8'd0) || (int'(i_RxByte) > MAX_LEN);
  assign o_Valid = (state == DRAIN);

  always_comb begin
    state_d   = state;
    len_d     = len;
    idx_d     = idx;
    rd_d      = rd;
    sum_d     = sum;
    timer_d   = '0;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    ovr_d     = 1'b0;
    we        = 1'b0;
    timer_run = (state == LEN) || (state == PAYLOAD) || (state == CHK);
    timeout   = timer_run && !strobe && (timer == TW'(TIMEOUT_CYCLES - 1));
    if (timer_run && !strobe) timer_d = timer + 1'b1;

    case (state)
      HUNT: begin
        if (strobe && (i_RxByte == SYNC_BYTE)) state_d = LEN;
      end
      LEN: begin
        if (strobe) begin
          if (len_bad) begin
            state_d = HUNT;
            err_d   = 1'b1;
          end else begin
            len_d   = CW'(i_RxByte);
            sum_d   = i_RxByte;
            idx_d   = '0;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (strobe) begin
          we    = 1'b1;
          sum_d = sum + i_RxByte;
          idx_d = idx + 1'b1;
          if (idx_d == len) state_d = CHK;
        end
      end
      CHK: begin
        if (strobe) begin
          if (i_RxByte == sum) begin
            state_d = DRAIN;
            ok_d    = 1'b1;
            rd_d    = '0;
          end else begin
            state_d = HUNT;
            err_d   = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (i_Ready) begin
          rd_d = rd + 1'b1;
          if (rd_d == len) state_d = HUNT;
        end
        if (strobe) ovr_d = 1'b1;
      end
      default: state_d = HUNT;
    endcase

    if (timeout) begin
      state_d = HUNT;
      err_d   = 1'b1;
      timer_d = '0;
    end

    // Read side is addressed with the next rd so o_Data/o_Last land in step with rd.
    last_d = (state_d == DRAIN) && ((rd_d + 1'b1) == len);
  end

  always_ff @(posedge i_SysClock or posedge i_Reset) begin
    if (i_Reset) begin
      state      <= HUNT;
      done_q     <= 1'b1;
      len        <= '0;
      idx        <= '0;
      rd         <= '0;
      sum        <= '0;
      timer      <= '0;
      o_FrameOk  <= 1'b0;
      o_FrameErr <= 1'b0;
      o_Overrun  <= 1'b0;
      o_Last     <= 1'b0;
    end else begin
      state      <= state_d;
      done_q     <= i_RxDone;
      len        <= len_d;
      idx        <= idx_d;
      rd         <= rd_d;
      sum        <= sum_d;
      timer      <= timer_d;
      o_FrameOk  <= ok_d;
      o_FrameErr <= err_d;
      o_Overrun  <= ovr_d;
      o_Last     <= last_d;
    end
  end

  uart_payload_buf #(
    .DEPTH(MAX_LEN),
    .AW   (BAW)
  ) u_buf (
    .clk  (i_SysClock),
    .rst  (i_Reset),
    .we   (we),
    .waddr(idx[BAW-1:0]),
    .wdata(i_RxByte),
    .raddr(rd_d[BAW-1:0]),
    .rdata(o_Data)
  );

endmodule
